// File: rtl/core_pkg.sv
// Shared definitions for the load/store path: access widths, opcodes,
// FSM state encoding and error codes.
package core_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } mem_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_data_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it
// to register width. Purely combinational so a cache can reuse it.
module load_data_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      byte_off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  // Shift the addressed lane down to bit 0, then extend per access width.
  always_comb begin
    shifted = rdata_i >> {byte_off_i, 3'b000};
    data_o  = rdata_i;
    case (funct3_i)
      LS_B:    data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LS_BU:   data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LS_H:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LS_HU:   data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store unit: accepts one memory op from EX, runs the req/gnt/rvalid
// handshake with data memory, formats load data and flags bad accesses.
//
//  state        | meaning
//  ST_IDLE      | ready for a new op; misaligned/illegal ops are rejected here
//  ST_REQ       | dmem_req held with stable address/data until gnt
//  ST_WAIT_RESP | load granted, waiting for rvalid
module data_mem_access_unit
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write_in,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rd,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_reg_write,
  output logic            err,
  output logic [1:0]      err_code
);

  mem_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic            regw_q, regw_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_regw_q, wb_regw_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            misal, legal, timeout_hit, in_req;
  logic [3:0]      fmt_be;
  logic [XLEN-1:0] fmt_wdata, load_fmt;

  load_data_align #(.XLEN(XLEN)) u_align (
    .rdata_i    (dmem_rdata),
    .byte_off_i (addr_q[1:0]),
    .funct3_i   (f3_q),
    .data_o     (load_fmt)
  );

  // Request legality and lane formatting of the incoming store data.
  always_comb begin
    misal       = is_misaligned(funct3, addr[1:0]);
    legal       = (mem_read ^ mem_write) & ~misal;
    timeout_hit = (cnt_q == 8'(TIMEOUT_CYC - 1));
    fmt_be      = 4'b1111;
    fmt_wdata   = wdata;
    case (funct3[1:0])
      2'b00: begin
        fmt_be    = 4'b0001 << addr[1:0];
        fmt_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        fmt_be    = addr[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{wdata[15:0]}};
      end
      default: begin
        fmt_be    = 4'b1111;
        fmt_wdata = wdata;
      end
    endcase
  end

  // Next-state, operand latching, writeback and error pulses.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    regw_d     = regw_q;
    cnt_d      = cnt_q + 8'd1;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_regw_d  = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (req_valid) begin
          if (mem_read & mem_write) begin
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if ((mem_read | mem_write) & misal) begin
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end else if (legal) begin
            we_d    = mem_write;
            addr_d  = addr;
            be_d    = fmt_be;
            wdata_d = fmt_wdata;
            f3_d    = funct3;
            rd_d    = rd;
            regw_d  = reg_write_in;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          // Any rvalid in the grant cycle belongs to no one and is dropped.
          state_d = we_q ? ST_IDLE : ST_WAIT_RESP;
          cnt_d   = 8'd0;
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_WAIT_RESP: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = load_fmt;
          wb_rd_d    = rd_q;
          wb_regw_d  = regw_q & (rd_q != 5'd0);
          state_d    = ST_IDLE;
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      f3_q       <= 3'b000;
      rd_q       <= 5'd0;
      regw_q     <= 1'b0;
      cnt_q      <= 8'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      wb_regw_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      regw_q     <= regw_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_regw_q  <= wb_regw_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Memory-side outputs are driven only while requesting, so they fall with the state.
  always_comb begin
    in_req       = (state_q == ST_REQ);
    req_ready    = (state_q == ST_IDLE);
    stall        = (state_q != ST_IDLE) | (req_valid & (mem_read | mem_write) & legal);
    dmem_req     = in_req;
    dmem_we      = in_req & we_q;
    dmem_addr    = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_be      = in_req ? be_q : 4'b0000;
    dmem_wdata   = in_req ? wdata_q : '0;
    wb_valid     = wb_valid_q;
    wb_rd        = wb_rd_q;
    wb_data      = wb_data_q;
    wb_reg_write = wb_regw_q;
    err          = err_q;
    err_code     = err_code_q;
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed and randomized checks of the load/store unit against a
// behavioural model of load formatting and store lane placement.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, mem_read, mem_write, reg_write_in;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic        wb_valid, wb_reg_write, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;

  data_mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write_in(reg_write_in),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: take the addressed lane, then sign- or zero-extend numerically.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (int'(a[1:0]) * 8);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b100: v = v & 32'hFF;
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b101: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    case (f3[1:0])
      2'b00:   return 4'(1 << off);
      2'b01:   return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write_in = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; rd = 5'd0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word,
                         input logic [31:0] exp, input logic [4:0] rdi, input logic rw,
                         input int gw, input int rvw);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg_write_in = rw;
    funct3 = f3; addr = a; wdata = $urandom; rd = rdi;
    #1;
    chk("ld_accept_stall", 32'(stall), 32'd1);
    chk("ld_accept_ready", 32'(req_ready), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("ld_req", 32'(dmem_req), 32'd1);
    chk("ld_addr", dmem_addr, a & 32'hFFFF_FFFC);
    chk("ld_we", 32'(dmem_we), 32'd0);
    for (int i = 0; i < gw; i++) begin
      step();
      chk("ld_req_hold", 32'(dmem_req), 32'd1);
      chk("ld_addr_hold", dmem_addr, a & 32'hFFFF_FFFC);
      chk("ld_stall_hold", 32'(stall), 32'd1);
    end
    dmem_gnt = 1'b1;
    dmem_rvalid = (rvw > 0);
    dmem_rdata = $urandom;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    #1;
    chk("ld_req_drop", 32'(dmem_req), 32'd0);
    chk("ld_no_early_wb", 32'(wb_valid), 32'd0);
    chk("ld_wait_stall", 32'(stall), 32'd1);
    for (int i = 0; i < rvw; i++) begin
      step();
      chk("ld_wait_no_wb", 32'(wb_valid), 32'd0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = word;
    step();
    dmem_rvalid = 1'b0;
    #1;
    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld_wb_data", wb_data, exp);
    chk("ld_wb_rd", 32'(wb_rd), 32'(rdi));
    chk("ld_wb_regw", 32'(wb_reg_write), 32'(rw && (rdi != 5'd0)));
    chk("ld_done_ready", 32'(req_ready), 32'd1);
    step();
    chk("ld_wb_pulse", 32'(wb_valid), 32'd0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] ebe, input logic [31:0] ewd, input int gw);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; reg_write_in = 1'b0;
    funct3 = f3; addr = a; wdata = d; rd = 5'($urandom);
    #1;
    chk("st_accept_stall", 32'(stall), 32'd1);
    step();
    idle_inputs();
    for (int i = 0; i <= gw; i++) begin
      #1;
      chk("st_req", 32'(dmem_req), 32'd1);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_addr", dmem_addr, a & 32'hFFFF_FFFC);
      chk("st_be", 32'(dmem_be), 32'(ebe));
      chk("st_wdata", dmem_wdata, ewd);
      if (i < gw) step();
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    chk("st_req_drop", 32'(dmem_req), 32'd0);
    chk("st_ready", 32'(req_ready), 32'd1);
    chk("st_no_stall", 32'(stall), 32'd0);
    chk("st_no_wb", 32'(wb_valid), 32'd0);
    step();
    chk("st_no_wb_late", 32'(wb_valid), 32'd0);
  endtask

  task automatic do_err(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] code);
    req_valid = 1'b1; mem_read = r; mem_write = w; reg_write_in = r;
    funct3 = f3; addr = a; wdata = $urandom; rd = 5'd3;
    #1;
    chk("err_no_stall", 32'(stall), 32'd0);
    step();
    idle_inputs();
    #1;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_code", 32'(err_code), 32'(code));
    chk("err_no_req", 32'(dmem_req), 32'd0);
    chk("err_ready", 32'(req_ready), 32'd1);
    step();
    chk("err_pulse_end", 32'(err), 32'd0);
    chk("err_no_req_late", 32'(dmem_req), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0]  ld_f3 [5];
    logic [2:0]  f3r;
    logic [31:0] ar, dr;
    logic [4:0]  rdr;
    int          n;
    logic        stable;

    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
    ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    idle_inputs();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    rst_n = 1'b0;
    #2;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Zero-wait load: req in cycle 1, rvalid in cycle 2, writeback in cycle 3.
    do_load(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 5'd5, 1'b1, 0, 0);
    do_load(3'b000, 32'h103, 32'h80FF_FF00, 32'hFFFF_FF80, 5'd7, 1'b1, 0, 0);
    do_load(3'b100, 32'h103, 32'h80FF_FF00, 32'h0000_0080, 5'd0, 1'b1, 1, 2);
    do_store(3'b001, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 0);
    do_store(3'b000, 32'h201, 32'h0000_00A5, 4'b0010, 32'hA5A5A5A5, 5);
    do_err(1'b1, 1'b0, 3'b010, 32'h101, 2'b01);
    do_err(1'b1, 1'b0, 3'b001, 32'h203, 2'b01);
    do_err(1'b1, 1'b1, 3'b010, 32'h100, 2'b10);

    // Neither read nor write: no stall, no request, no error.
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'h40;
    #1;
    chk("nop_stall", 32'(stall), 32'd0);
    step();
    idle_inputs();
    chk("nop_req", 32'(dmem_req), 32'd0);
    chk("nop_err", 32'(err), 32'd0);

    // Grant never arrives: request held 255 cycles then aborted.
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; rd = 5'd9;
    reg_write_in = 1'b1;
    step();
    idle_inputs();
    #1;
    n = 0;
    stable = 1'b1;
    while (dmem_req === 1'b1 && n < 400) begin
      n++;
      if (dmem_addr !== 32'h300 || stall !== 1'b1) stable = 1'b0;
      step();
    end
    chk("to_req_cycles", 32'(n), 32'd255);
    chk("to_stable", 32'(stable), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_code", 32'(err_code), 32'd3);
    chk("to_no_wb", 32'(wb_valid), 32'd0);
    step();
    chk("to_err_pulse", 32'(err), 32'd0);

    // Reset while waiting for read data.
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; rd = 5'd4;
    step();
    idle_inputs();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_be", 32'(dmem_be), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_load(3'b010, 32'h104, 32'h0BADF00D, 32'h0BADF00D, 5'd12, 1'b1, 0, 0);

    for (int k = 0; k < 20; k++) begin
      f3r = ld_f3[$urandom_range(0, 4)];
      ar = $urandom;
      if (f3r[1:0] == 2'b01) ar = ar & 32'hFFFF_FFFE;
      if (f3r[1:0] == 2'b10) ar = ar & 32'hFFFF_FFFC;
      dr = $urandom;
      rdr = 5'($urandom);
      do_load(f3r, ar, dr, exp_load(f3r, ar, dr), rdr, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 10; k++) begin
      f3r = 3'($urandom_range(0, 2));
      ar = $urandom;
      if (f3r == 3'b001) ar = ar & 32'hFFFF_FFFE;
      if (f3r == 3'b010) ar = ar & 32'hFFFF_FFFC;
      dr = $urandom;
      do_store(f3r, ar, dr, exp_be(f3r, ar), exp_wd(f3r, dr), int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 4; k++) begin
      ar = ($urandom & 32'hFFFF_FFFC) | 32'(1 + $urandom_range(0, 2));
      do_err(1'b0, 1'b1, 3'b010, ar, 2'b01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
